// File: rtl/caliptra_prim_arb_skid_pkg.sv
// rtl/caliptra_prim_arb_skid_pkg.sv - shared types and constants for the arbiter output skid stage
package caliptra_prim_arb_skid_pkg;

    // State encoding equals the number of buffered entries.
    typedef enum logic [1:0] {
        SkidEmpty = 2'd0,
        SkidOne   = 2'd1,
        SkidFull  = 2'd2
    } skid_state_e;

    localparam logic [1:0] OccEmpty = 2'd0;
    localparam logic [1:0] OccOne   = 2'd1;
    localparam logic [1:0] OccFull  = 2'd2;

    // Occupancy reported for a given state; unused encodings read as empty.
    function automatic logic [1:0] occ_of(skid_state_e s);
        logic [1:0] occ;
        case (s)
            SkidOne:  occ = OccOne;
            SkidFull: occ = OccFull;
            default:  occ = OccEmpty;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/caliptra_prim_sat_cnt.sv
// rtl/caliptra_prim_sat_cnt.sv - saturating up-counter with synchronous clear
module caliptra_prim_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment; increment stops at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/caliptra_prim_arb_out_skid.sv
// rtl/caliptra_prim_arb_out_skid.sv - registered 2-entry skid stage behind the N:1 arbiter with per-source counters
module caliptra_prim_arb_out_skid
    import caliptra_prim_arb_skid_pkg::*;
#(
    parameter int N    = 8,
    parameter int DW   = 32,
    parameter int CntW = 16,
    localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [DW-1:0]     data_i,
    input  logic [IdxW-1:0]   idx_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DW-1:0]     data_o,
    output logic [IdxW-1:0]   idx_o,
    input  logic              ready_i,
    input  logic              flush_i,
    input  logic              clr_cnt_i,
    output logic [1:0]        occ_o,
    output logic [N*CntW-1:0] cnt_o
);

    skid_state_e     state_q, state_d;
    logic [DW-1:0]   main_data_q, main_data_d;
    logic [IdxW-1:0] main_idx_q, main_idx_d;
    logic [DW-1:0]   skid_data_q, skid_data_d;
    logic [IdxW-1:0] skid_idx_q, skid_idx_d;

    logic up_xfer;
    logic dn_xfer;

    // ready_o is built only from registered state and flush, never from ready_i.
    assign ready_o = (state_q != SkidFull) & ~flush_i;
    assign valid_o = (state_q != SkidEmpty);
    assign occ_o   = occ_of(state_q);
    assign data_o  = main_data_q;

    assign up_xfer = valid_i & ready_o;
    assign dn_xfer = valid_o & ready_i;

    // Next-state and datapath selection; flush drops everything and leaves the
    // output registers untouched so data_o keeps its last presented value.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_idx_d  = main_idx_q;
        skid_data_d = skid_data_q;
        skid_idx_d  = skid_idx_q;
        if (flush_i) begin
            state_d = SkidEmpty;
        end else begin
            case (state_q)
                SkidEmpty: begin
                    if (up_xfer) begin
                        main_data_d = data_i;
                        main_idx_d  = idx_i;
                        state_d     = SkidOne;
                    end
                end
                SkidOne: begin
                    if (up_xfer && dn_xfer) begin
                        main_data_d = data_i;
                        main_idx_d  = idx_i;
                    end else if (up_xfer) begin
                        skid_data_d = data_i;
                        skid_idx_d  = idx_i;
                        state_d     = SkidFull;
                    end else if (dn_xfer) begin
                        state_d = SkidEmpty;
                    end
                end
                SkidFull: begin
                    if (dn_xfer) begin
                        main_data_d = skid_data_q;
                        main_idx_d  = skid_idx_q;
                        state_d     = SkidOne;
                    end
                end
                default: state_d = SkidEmpty;
            endcase
        end
    end

    // State and entry registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= SkidEmpty;
            main_data_q <= '0;
            main_idx_q  <= '0;
            skid_data_q <= '0;
            skid_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_idx_q  <= main_idx_d;
            skid_data_q <= skid_data_d;
            skid_idx_q  <= skid_idx_d;
        end
    end

    // With a single source the index carries no information.
    if (N == 1) begin : g_single
        logic unused_idx;
        assign unused_idx = ^{main_idx_q, skid_idx_q};
        assign idx_o      = '0;
    end else begin : g_multi
        assign idx_o = main_idx_q;
    end

    // One counter per source; an out-of-range index matches no counter.
    for (genvar k = 0; k < N; k++) begin : g_cnt
        localparam logic [IdxW-1:0] KIdx = IdxW'(k);
        logic inc;
        assign inc = dn_xfer & (idx_o == KIdx);
        caliptra_prim_sat_cnt #(
            .W(CntW)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clr_cnt_i),
            .inc_i (inc),
            .cnt_o (cnt_o[k*CntW +: CntW])
        );
    end

`ifndef SYNTHESIS
    // The arbiter holds its offer until it is accepted.
    a_input_hold: assume property (@(posedge clk_i) disable iff (rst_i)
        (valid_i && !ready_o) |=> (valid_i && $stable(data_i) && $stable(idx_i)));

    // A full buffer never advertises space.
    a_full_not_ready: assert property (@(posedge clk_i) disable iff (rst_i)
        (occ_o == OccFull) |-> !ready_o);

    // Valid mirrors non-zero occupancy.
    a_valid_occ: assert property (@(posedge clk_i) disable iff (rst_i)
        valid_o == (occ_o != OccEmpty));

    // Presented entry is frozen while the consumer stalls.
    a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i && !flush_i) |=> (valid_o && $stable(data_o) && $stable(idx_o)));

    // Occupancy is bounded by the two entries.
    a_occ_max: assert property (@(posedge clk_i) disable iff (rst_i)
        occ_o <= OccFull);

    // Control outputs are always driven to known values.
    a_known: assert property (@(posedge clk_i) disable iff (rst_i)
        !$isunknown({valid_o, ready_o, idx_o, occ_o}));
`endif

endmodule

// File: tb/tb_caliptra_prim_arb_out_skid.sv
// tb/tb_caliptra_prim_arb_out_skid.sv - directed self-checking bench for caliptra_prim_arb_out_skid
module tb_caliptra_prim_arb_out_skid;

    localparam int N    = 8;
    localparam int DW   = 32;
    localparam int CntW = 2;
    localparam int IdxW = 3;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              valid_i;
    logic [DW-1:0]     data_i;
    logic [IdxW-1:0]   idx_i;
    logic              ready_o;
    logic              valid_o;
    logic [DW-1:0]     data_o;
    logic [IdxW-1:0]   idx_o;
    logic              ready_i;
    logic              flush_i;
    logic              clr_cnt_i;
    logic [1:0]        occ_o;
    logic [N*CntW-1:0] cnt_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    caliptra_prim_arb_out_skid #(
        .N    (N),
        .DW   (DW),
        .CntW (CntW)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .idx_i     (idx_i),
        .ready_o   (ready_o),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .idx_o     (idx_o),
        .ready_i   (ready_i),
        .flush_i   (flush_i),
        .clr_cnt_i (clr_cnt_i),
        .occ_o     (occ_o),
        .cnt_o     (cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] cnt_of(input int k);
        return 32'(cnt_o[k*CntW +: CntW]);
    endfunction

    task automatic push(input logic [DW-1:0] d, input logic [IdxW-1:0] ix);
        valid_i = 1'b1;
        data_i  = d;
        idx_i   = ix;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic clear_cnt();
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        chk("cnt_cleared", 32'(cnt_o), 32'h0);
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; data_i = '0; idx_i = '0;
        ready_i = 1'b0; flush_i = 1'b0; clr_cnt_i = 1'b0;
        tick();
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_ready", 32'(ready_o), 32'h1);
        chk("rst_occ",   32'(occ_o),   32'h0);
        chk("rst_data",  data_o,       32'h0);
        chk("rst_idx",   32'(idx_o),   32'h0);
        chk("rst_cnt",   32'(cnt_o),   32'h0);
        rst_i = 1'b0;

        // Full throughput: one accepted per cycle, seen one cycle later.
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1;
            data_i  = 32'hA0 + 32'(i);
            idx_i   = IdxW'(i);
            #1;
            chk("tp_ready", 32'(ready_o), 32'h1);
            tick();
            chk("tp_valid", 32'(valid_o), 32'h1);
            chk("tp_data",  data_o,       32'hA0 + 32'(i));
            chk("tp_idx",   32'(idx_o),   32'(i));
            chk("tp_occ",   32'(occ_o),   32'h1);
        end
        valid_i = 1'b0;
        tick();
        chk("tp_drain_occ", 32'(occ_o), 32'h0);
        chk("tp_cnt_all",   32'(cnt_o), 32'h5555);
        clear_cnt();

        // Backpressure: second entry lands in skid, output held.
        ready_i = 1'b0;
        push(32'h11, 3'd2);
        chk("bp_occ1", 32'(occ_o), 32'h1);
        valid_i = 1'b1; data_i = 32'h22; idx_i = 3'd5;
        #1;
        chk("bp_ready_one", 32'(ready_o), 32'h1);
        tick();
        valid_i = 1'b0;
        chk("bp_occ2",  32'(occ_o),   32'h2);
        chk("bp_ready", 32'(ready_o), 32'h0);
        chk("bp_data",  data_o,       32'h11);
        chk("bp_idx",   32'(idx_o),   32'h2);
        tick();
        chk("bp_hold_data", data_o, 32'h11);
        ready_i = 1'b1;
        tick();
        chk("bp_drain1_data", data_o,       32'h22);
        chk("bp_drain1_idx",  32'(idx_o),   32'h5);
        chk("bp_drain1_occ",  32'(occ_o),   32'h1);
        tick();
        chk("bp_drain2_occ",  32'(occ_o),   32'h0);
        chk("bp_drain2_valid",32'(valid_o), 32'h0);
        chk("bp_hold_last",   data_o,       32'h22);
        chk("bp_cnt2", cnt_of(2), 32'h1);
        chk("bp_cnt5", cnt_of(5), 32'h1);
        clear_cnt();

        // Flush while full: head transfer completes, skid dropped.
        ready_i = 1'b0;
        push(32'h11, 3'd2);
        push(32'h22, 3'd5);
        chk("fl_occ2", 32'(occ_o), 32'h2);
        ready_i = 1'b1; flush_i = 1'b1;
        #1;
        chk("fl_ready", 32'(ready_o), 32'h0);
        tick();
        flush_i = 1'b0;
        chk("fl_occ",   32'(occ_o),   32'h0);
        chk("fl_valid", 32'(valid_o), 32'h0);
        chk("fl_cnt2",  cnt_of(2),    32'h1);
        tick();
        tick();
        chk("fl_no_stale", 32'(valid_o), 32'h0);
        chk("fl_cnt5",     cnt_of(5),    32'h0);
        clear_cnt();

        // Saturation at 3 for a 2-bit counter, then clear beats increment.
        ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; data_i = 32'h50 + 32'(i); idx_i = 3'd3;
            tick();
        end
        valid_i = 1'b0;
        tick();
        chk("sat_cnt3", cnt_of(3), 32'h3);
        push(32'h60, 3'd3);
        clr_cnt_i = 1'b1;
        tick();
        clr_cnt_i = 1'b0;
        chk("sat_clr_wins", cnt_of(3),   32'h0);
        chk("sat_clr_occ",  32'(occ_o), 32'h0);

        // Simultaneous accept and drain in ONE.
        ready_i = 1'b0;
        push(32'h33, 3'd1);
        chk("sim_data0", data_o, 32'h33);
        ready_i = 1'b1;
        valid_i = 1'b1; data_i = 32'h44; idx_i = 3'd4;
        #1;
        chk("sim_ready_pre", 32'(ready_o), 32'h1);
        tick();
        valid_i = 1'b0;
        chk("sim_data",  data_o,       32'h44);
        chk("sim_idx",   32'(idx_o),   32'h4);
        chk("sim_occ",   32'(occ_o),   32'h1);
        chk("sim_ready", 32'(ready_o), 32'h1);
        chk("sim_cnt1",  cnt_of(1),    32'h1);
        tick();
        chk("sim_cnt4",  cnt_of(4),    32'h1);

        // Asynchronous reset while full clears everything immediately.
        ready_i = 1'b0;
        push(32'h77, 3'd6);
        push(32'h88, 3'd7);
        chk("rm_occ2", 32'(occ_o), 32'h2);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rm_valid", 32'(valid_o), 32'h0);
        chk("rm_ready", 32'(ready_o), 32'h1);
        chk("rm_occ",   32'(occ_o),   32'h0);
        chk("rm_cnt",   32'(cnt_o),   32'h0);
        tick();
        rst_i = 1'b0;
        ready_i = 1'b1;
        tick();
        chk("rm_no_stale1", 32'(valid_o), 32'h0);
        tick();
        chk("rm_no_stale2", 32'(valid_o), 32'h0);
        chk("rm_cnt_after", 32'(cnt_o),   32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
